cross_bar_arbiter: RTL and testbench
====================================

# cross_bar_arbiter

Per-slave round-robin arbiter for the 4x4 cross bar. Decodes each master's request address to a target slave, selects one requesting master per slave, and drives the registered one-hot `granted_matrix` consumed by `commutation_block`. Holds each grant until that slave's `session_is_finished` pulse or until a watchdog timeout expires.

## Interface
- `QTY_OF_DEVICES`, default 4: number of masters, equal to the number of slaves. Must be a power of two, ≥2.
- `ADDR_WIDTH`, default `interface_connection::ADDR_WIDTH`: master address width.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles a grant may be held. 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `master_req`  in  `[QTY_OF_DEVICES-1:0]`  `_req` of each master.
- `master_addr`  in  `[ADDR_WIDTH-1:0] x QTY_OF_DEVICES` (unpacked)  `_addr` of each master.
- `session_is_finished`  in  `1 x QTY_OF_DEVICES` (unpacked)  per-slave end-of-session pulse from `commutation_block`.
- `granted_matrix`  out  `[QTY_OF_DEVICES-1:0] x QTY_OF_DEVICES` (unpacked)  row s = one-hot granted master at slave s, bit m = master m.
- `slave_busy`  out  `[QTY_OF_DEVICES-1:0]`  slave s holds a grant.
- `timeout_err`  out  `[QTY_OF_DEVICES-1:0]`  one-cycle pulse when the watchdog releases slave s.

## Operation
- **Address decode.**
  - `SEL_W = $clog2(QTY_OF_DEVICES)`.
  - Master m targets slave `master_addr[m][ADDR_WIDTH-1 -: SEL_W]`.
  - Request vector for slave s: `r_s[m] = master_req[m] && target(m) == s`.
  - Mutual exclusion across slaves follows from decode. A master targets exactly one slave. The protocol forbids changing `_addr` while `_req` is high.
- **Per-slave FSM, two states.**
  - **IDLE**
    - If `|r_s`, pick a winner w by round robin.
    - Register `granted_matrix[s] <= 1<<w` and `slave_busy[s] <= 1`.
    - Load `ptr_s <= (w+1) mod QTY_OF_DEVICES`, clear the watchdog counter, go to BUSY.
    - If `r_s == 0`, stay in IDLE with the row at 0.
  - **BUSY**
    - The row is held constant regardless of `master_req`. A master that drops `_req` does not release the slave.
    - If `session_is_finished[s]` is sampled 1: row <= 0, `slave_busy[s] <= 0`, go to IDLE.
    - Else, if the watchdog is enabled and `cnt_s == TIMEOUT_CYCLES-1`: row <= 0, `slave_busy[s] <= 0`, `timeout_err[s] <= 1` for one cycle, go to IDLE.
    - Else `cnt_s <= cnt_s + 1`.
- **Round robin.**
  - Scan m = `ptr_s`, `ptr_s+1`, … modulo `QTY_OF_DEVICES`. The first m with `r_s[m]` wins.
  - The pointer wraps from `QTY_OF_DEVICES-1` to 0.
  - The pointer updates only on a grant.
- **Counter.**
  - Width `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit.
  - Never wraps: it is cleared on every grant.
- **Simultaneous events.**
  - Finish and timeout in the same cycle: finish wins, `timeout_err` stays 0.
  - Finish and a pending request in the same cycle: release only. Re-arbitration happens in the following IDLE cycle.
- **Independence.** All slaves arbitrate independently and in parallel. Up to `QTY_OF_DEVICES` grants can be active simultaneously.
- **Reset values** (all asynchronous):
  - `granted_matrix` rows: 0.
  - `slave_busy`: 0.
  - `timeout_err`: 0.
  - `ptr_s`: 0.
  - `cnt_s`: 0.
  - All FSMs: IDLE.
  - Reset mid-session drops every grant immediately.

## Timing
- **Grant latency.** Request sampled at edge k while IDLE → row valid after edge k.
- **Release.**
  - `session_is_finished[s]` sampled 1 at edge k → row 0 after edge k.
  - The earliest new grant appears after edge k+1, giving a minimum one-cycle gap with row 0.
- **Timeout.**
  - Grant asserted after edge g, no finish → row cleared after edge g+`TIMEOUT_CYCLES`.
  - `timeout_err[s]` is high for the cycle after edge g+`TIMEOUT_CYCLES` only.
- **Glitch-free outputs.** All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset.**
  - Stimulus: assert `rst_n`=0 with `master_req`=4'hF.
  - Required response: all rows, `slave_busy` and `timeout_err` stay 0. After release of reset, the first grant at each slave goes to the lowest-index requester.
- **Single transfer.**
  - Stimulus: M2 requests S1 (addr top bits 2'b01).
  - Required response: `granted_matrix[1]`=4'b0100 one edge later. The row is held while M2 drops `_req`. A one-cycle `session_is_finished[1]` clears it on that edge.
- **Contention.**
  - Stimulus: M0, M1, M3 continuously request S0, with a finish pulse 3 cycles after each grant.
  - Required response: grant order M0, M1, M3, M0, M1.
  - The row is 0 for exactly one cycle between grants.
- **Parallel.**
  - Stimulus: M0→S3, M1→S2, M3→S0 in the same cycle.
  - Required response: rows 3, 2 and 0 are 4'b0001, 4'b0010 and 4'b1000 on the same edge.
- **Watchdog.**
  - Stimulus: `TIMEOUT_CYCLES`=8, M1→S2, no finish.
  - Required response: the grant is held 8 cycles, then released, with a single-cycle `timeout_err[2]` pulse.
  - Repeat with finish and timeout on the same edge: release occurs with no error.
- **Reset mid-session.**
  - Stimulus: pulse `rst_n` low while S1 is BUSY with M3, whose request stays high.
  - Required response: the row clears asynchronously. After reset, M3 is re-granted one edge later with `ptr_1` restarted from 0.

Source files
------------

// File: rtl/interface_connection.sv
// rtl/interface_connection.sv - shared cross bar interface parameters
package interface_connection;
    localparam int ADDR_WIDTH = 32;
endpackage

// File: rtl/cross_bar_arbiter.sv
// rtl/cross_bar_arbiter.sv - per-slave round-robin arbiter driving the cross bar grant matrix
module cross_bar_arbiter #(
    parameter int QTY_OF_DEVICES = 4,
    parameter int ADDR_WIDTH     = interface_connection::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [QTY_OF_DEVICES-1:0] master_req,
    input  logic [ADDR_WIDTH-1:0]     master_addr [QTY_OF_DEVICES],
    input  logic                      session_is_finished [QTY_OF_DEVICES],
    output logic [QTY_OF_DEVICES-1:0] granted_matrix [QTY_OF_DEVICES],
    output logic [QTY_OF_DEVICES-1:0] slave_busy,
    output logic [QTY_OF_DEVICES-1:0] timeout_err
);

    localparam int SEL_W   = $clog2(QTY_OF_DEVICES);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [SEL_W-1:0]          target [QTY_OF_DEVICES];
    logic [QTY_OF_DEVICES-1:0] unused_addr;

    // Only the top SEL_W address bits select a slave; the rest belong to the slave.
    for (genvar m = 0; m < QTY_OF_DEVICES; m++) begin : g_decode
        assign target[m]      = master_addr[m][ADDR_WIDTH-1 -: SEL_W];
        assign unused_addr[m] = ^master_addr[m];
    end

    for (genvar s = 0; s < QTY_OF_DEVICES; s++) begin : g_slave
        logic [QTY_OF_DEVICES-1:0] req_vec;
        logic [SEL_W-1:0]          ptr_q;
        logic [SEL_W-1:0]          scan_idx;
        logic [SEL_W-1:0]          win;
        logic                      win_vld;
        logic [CNT_W-1:0]          cnt_q;
        state_t                    state_q;
        logic [QTY_OF_DEVICES-1:0] row_q;
        logic                      busy_q;
        logic                      tout_q;

        always_comb begin
            req_vec = '0;
            for (int m = 0; m < QTY_OF_DEVICES; m++) begin
                req_vec[m] = master_req[m] && (target[m] == SEL_W'(s));
            end
        end

        // Power-of-two device count lets the rotating index wrap by truncation.
        always_comb begin
            win      = '0;
            win_vld  = 1'b0;
            scan_idx = '0;
            for (int i = 0; i < QTY_OF_DEVICES; i++) begin
                scan_idx = ptr_q + SEL_W'(i);
                if (!win_vld && req_vec[scan_idx]) begin
                    win     = scan_idx;
                    win_vld = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                row_q   <= '0;
                busy_q  <= 1'b0;
                tout_q  <= 1'b0;
                ptr_q   <= '0;
                cnt_q   <= '0;
            end else begin
                tout_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (win_vld) begin
                            row_q   <= QTY_OF_DEVICES'(1) << win;
                            busy_q  <= 1'b1;
                            ptr_q   <= win + 1'b1;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        // Finish takes priority so a coincident timeout raises no error.
                        if (session_is_finished[s]) begin
                            row_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                            row_q   <= '0;
                            busy_q  <= 1'b0;
                            tout_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (WDOG_EN) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign granted_matrix[s] = row_q;
        assign slave_busy[s]     = busy_q;
        assign timeout_err[s]    = tout_q;
    end

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// tb/tb_cross_bar_arbiter.sv - self-checking bench for cross_bar_arbiter
module tb_cross_bar_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  master_req;
    logic [AW-1:0] master_addr [N];
    logic          session_is_finished [N];
    logic [N-1:0]  granted_matrix [N];
    logic [N-1:0]  slave_busy;
    logic [N-1:0]  timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cross_bar_arbiter #(
        .QTY_OF_DEVICES (N),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .master_req          (master_req),
        .master_addr         (master_addr),
        .session_is_finished (session_is_finished),
        .granted_matrix      (granted_matrix),
        .slave_busy          (slave_busy),
        .timeout_err         (timeout_err)
    );

    typedef struct packed {
        logic [3:0]      req;
        logic [3:0][1:0] tgt;
        logic [3:0]      fin;
        logic [15:0]     rows;
        logic [3:0]      busy;
        logic [3:0]      err;
    } vec_t;

    vec_t vecs [12];

    int  m_owner [N];
    int  m_ptr   [N];
    int  m_age   [N];
    bit  m_err   [N];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rows();
        return {granted_matrix[3], granted_matrix[2], granted_matrix[1], granted_matrix[0]};
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [7:0] tgt, input logic [3:0] fin,
                                input logic [15:0] r, input logic [3:0] busy, input logic [3:0] err);
        vec_t v;
        v.req  = req;
        v.tgt  = tgt;
        v.fin  = fin;
        v.rows = r;
        v.busy = busy;
        v.err  = err;
        return v;
    endfunction

    task automatic set_fin(input logic [3:0] f);
        for (int i = 0; i < N; i++) session_is_finished[i] = f[i];
    endtask

    task automatic set_master(input int m, input logic req, input logic [1:0] slv);
        master_addr[m] = {slv, 6'(m * 7 + 1)};
        master_req[m]  = req;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        master_req = '0;
        set_fin(4'b0000);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_owner[s] = -1;
            m_ptr[s]   = 0;
            m_age[s]   = 0;
            m_err[s]   = 1'b0;
        end
    endtask

    // Reference behaviour: owner index per slave, next-priority master, hold age.
    task automatic model_step();
        for (int s = 0; s < N; s++) begin
            m_err[s] = 1'b0;
            if (m_owner[s] < 0) begin
                for (int k = 0; k < N; k++) begin
                    int m;
                    m = (m_ptr[s] + k) % N;
                    if (m_owner[s] < 0 && master_req[m] && int'(master_addr[m][AW-1 -: 2]) == s) begin
                        m_owner[s] = m;
                        m_ptr[s]   = (m + 1) % N;
                        m_age[s]   = 0;
                    end
                end
            end else if (session_is_finished[s]) begin
                m_owner[s] = -1;
            end else if (m_age[s] == TO - 1) begin
                m_owner[s] = -1;
                m_err[s]   = 1'b1;
            end else begin
                m_age[s]++;
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [15:0] er;
        logic [3:0]  eb;
        logic [3:0]  ee;
        er = '0;
        eb = '0;
        ee = '0;
        for (int s = 0; s < N; s++) begin
            if (m_owner[s] >= 0) begin
                er[s*4 + m_owner[s]] = 1'b1;
                eb[s] = 1'b1;
            end
            ee[s] = m_err[s];
        end
        check($sformatf("rand_rows_c%0d", cyc), rows(), er);
        check($sformatf("rand_busy_c%0d", cyc), 16'(slave_busy), 16'(eb));
        check($sformatf("rand_err_c%0d", cyc), 16'(timeout_err), 16'(ee));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [3:0] order [5];

        // Reset held with every master requesting: nothing may be granted.
        master_req = 4'hF;
        set_fin(4'b0000);
        set_master(0, 1'b1, 2'd0);
        set_master(1, 1'b1, 2'd0);
        set_master(2, 1'b1, 2'd1);
        set_master(3, 1'b1, 2'd1);
        step();
        check("reset_rows", rows(), 16'h0000);
        check("reset_busy", 16'(slave_busy), 16'h0);
        check("reset_err", 16'(timeout_err), 16'h0);
        step();
        check("reset_rows_hold", rows(), 16'h0000);
        rst_n = 1'b1;
        step();
        check("post_reset_lowest", rows(), 16'h0041);
        check("post_reset_busy", 16'(slave_busy), 16'h3);

        // Table: single transfer, rotation at S1, parallel grants, re-grant after release.
        vecs[0]  = mk(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0000, 16'h0040, 4'b0010, 4'b0000);
        vecs[1]  = mk(4'b0000, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0000, 16'h0040, 4'b0010, 4'b0000);
        vecs[2]  = mk(4'b0000, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0010, 16'h0000, 4'b0000, 4'b0000);
        vecs[3]  = mk(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 16'h0010, 4'b0010, 4'b0000);
        vecs[4]  = mk(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0010, 16'h0000, 4'b0000, 4'b0000);
        vecs[5]  = mk(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 16'h0040, 4'b0010, 4'b0000);
        vecs[6]  = mk(4'b0000, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0010, 16'h0000, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b1011, {2'd0, 2'd0, 2'd2, 2'd3}, 4'b0000, 16'h1208, 4'b1101, 4'b0000);
        vecs[8]  = mk(4'b1011, {2'd0, 2'd0, 2'd2, 2'd3}, 4'b0000, 16'h1208, 4'b1101, 4'b0000);
        vecs[9]  = mk(4'b1011, {2'd0, 2'd0, 2'd2, 2'd3}, 4'b1101, 16'h0000, 4'b0000, 4'b0000);
        vecs[10] = mk(4'b1011, {2'd0, 2'd0, 2'd2, 2'd3}, 4'b0000, 16'h1208, 4'b1101, 4'b0000);
        vecs[11] = mk(4'b0000, {2'd0, 2'd0, 2'd2, 2'd3}, 4'b1101, 16'h0000, 4'b0000, 4'b0000);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int m = 0; m < N; m++) set_master(m, vecs[i].req[m], vecs[i].tgt[m]);
            set_fin(vecs[i].fin);
            step();
            check($sformatf("vec%0d_rows", i), rows(), vecs[i].rows);
            check($sformatf("vec%0d_busy", i), 16'(slave_busy), 16'(vecs[i].busy));
            check($sformatf("vec%0d_err", i), 16'(timeout_err), 16'(vecs[i].err));
        end

        // Contention at S0 with a finish three cycles after each grant.
        do_reset();
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b1000;
        order[3] = 4'b0001;
        order[4] = 4'b0010;
        set_master(0, 1'b1, 2'd0);
        set_master(1, 1'b1, 2'd0);
        set_master(3, 1'b1, 2'd0);
        step();
        check("cont_grant0", 16'(granted_matrix[0]), 16'(order[0]));
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("cont_hold_a%0d", g), 16'(granted_matrix[0]), 16'(order[g]));
            step();
            check($sformatf("cont_hold_b%0d", g), 16'(granted_matrix[0]), 16'(order[g]));
            set_fin(4'b0001);
            step();
            check($sformatf("cont_gap%0d", g), 16'(granted_matrix[0]), 16'h0);
            set_fin(4'b0000);
            if (g < 4) begin
                step();
                check($sformatf("cont_grant%0d", g + 1), 16'(granted_matrix[0]), 16'(order[g + 1]));
            end
        end

        // Watchdog: held TO cycles, then released with a one-cycle error pulse.
        do_reset();
        set_master(1, 1'b1, 2'd2);
        step();
        check("wd_grant", rows(), 16'h0200);
        master_req = '0;
        for (int i = 1; i < TO; i++) begin
            step();
            check($sformatf("wd_hold%0d", i), rows(), 16'h0200);
            check($sformatf("wd_noerr%0d", i), 16'(timeout_err), 16'h0);
        end
        step();
        check("wd_release", rows(), 16'h0000);
        check("wd_busy", 16'(slave_busy), 16'h0);
        check("wd_err_pulse", 16'(timeout_err), 16'h4);
        step();
        check("wd_err_single", 16'(timeout_err), 16'h0);

        // Finish on the timeout edge: release without error.
        do_reset();
        set_master(1, 1'b1, 2'd2);
        step();
        check("wdf_grant", rows(), 16'h0200);
        master_req = '0;
        for (int i = 1; i < TO; i++) step();
        check("wdf_hold_last", rows(), 16'h0200);
        set_fin(4'b0100);
        step();
        set_fin(4'b0000);
        check("wdf_release", rows(), 16'h0000);
        check("wdf_no_err", 16'(timeout_err), 16'h0);
        step();
        check("wdf_no_err_next", 16'(timeout_err), 16'h0);

        // Asynchronous reset in the middle of a session.
        do_reset();
        set_master(3, 1'b1, 2'd1);
        step();
        check("rst_mid_grant", rows(), 16'h0080);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async_rows", rows(), 16'h0000);
        check("rst_mid_async_busy", 16'(slave_busy), 16'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("rst_mid_regrant", rows(), 16'h0080);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < N; m++) begin
                if (master_req[m]) begin
                    if ($urandom_range(5) == 0) master_req[m] = 1'b0;
                end else begin
                    master_addr[m] = AW'($urandom);
                    if ($urandom_range(1) == 0) master_req[m] = 1'b1;
                end
            end
            for (int s = 0; s < N; s++) session_is_finished[s] = ($urandom_range(4) == 0);
            step();
            model_step();
            model_compare(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
